// File: rtl/memory_access_unit_if.sv
// Control-unit request/response and 8-bit memory bus signals of the memory access unit.
// The unit itself uses the slave modport; the environment driving it uses master.
interface memory_access_unit_if;
  logic        req_read;
  logic        req_write;
  logic        req_wide;
  logic [15:0] addr_read;
  logic [15:0] addr_write;
  logic [15:0] wdata;
  logic        busy;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        wr_done;
  logic        err;
  logic [15:0] bus_addr;
  logic [7:0]  bus_rdata;
  logic [7:0]  bus_wdata;
  logic        bus_read;
  logic        bus_write;
  logic        bus_ready;

  modport slave (
    input  req_read, req_write, req_wide, addr_read, addr_write, wdata,
    input  bus_rdata, bus_ready,
    output busy, mem_ack, mem_data, wr_done, err,
    output bus_addr, bus_wdata, bus_read, bus_write
  );

  modport master (
    output req_read, req_write, req_wide, addr_read, addr_write, wdata,
    output bus_rdata, bus_ready,
    input  busy, mem_ack, mem_data, wr_done, err,
    input  bus_addr, bus_wdata, bus_read, bus_write
  );
endinterface

// File: rtl/memory_access_unit.sv
// Splits 8/16-bit register-file memory requests into byte transfers on an 8-bit bus,
// with a per-phase bus_ready timeout that aborts the access and flags err.
module memory_access_unit #(
  parameter logic [7:0] BUS_TIMEOUT = 8'd255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  memory_access_unit_if.slave  io_bus
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      r_state;
  logic        r_isRead;
  logic        r_wide;
  logic [15:0] r_addr;
  logic [7:0]  r_wdataHi;
  logic [7:0]  r_loByte;
  logic [7:0]  r_wait;
  logic        r_busy;
  logic        r_memAck;
  logic        r_wrDone;
  logic        r_err;
  logic [15:0] r_memData;
  logic [15:0] r_busAddr;
  logic [7:0]  r_busWdata;
  logic        r_busRead;
  logic        r_busWrite;

  logic        w_accept;
  logic        w_timeout;

  assign w_accept  = io_bus.req_read | io_bus.req_write;
  // True on the BUS_TIMEOUT-th consecutive cycle of bus_ready low within one phase.
  assign w_timeout = ({1'b0, r_wait} + 9'd1) >= {1'b0, BUS_TIMEOUT};

  // Outputs are computed alongside the next state so they are valid for the whole phase.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_isRead   <= 1'b0;
      r_wide     <= 1'b0;
      r_addr     <= 16'h0000;
      r_wdataHi  <= 8'h00;
      r_loByte   <= 8'h00;
      r_wait     <= 8'h00;
      r_busy     <= 1'b0;
      r_memAck   <= 1'b0;
      r_wrDone   <= 1'b0;
      r_err      <= 1'b0;
      r_memData  <= 16'h0000;
      r_busAddr  <= 16'h0000;
      r_busWdata <= 8'h00;
      r_busRead  <= 1'b0;
      r_busWrite <= 1'b0;
    end else begin
      r_memAck <= 1'b0;
      r_wrDone <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= LO;
            r_busy     <= 1'b1;
            r_isRead   <= io_bus.req_read;
            r_wide     <= io_bus.req_wide;
            r_addr     <= io_bus.req_read ? io_bus.addr_read : io_bus.addr_write;
            r_wdataHi  <= io_bus.wdata[15:8];
            r_busAddr  <= io_bus.req_read ? io_bus.addr_read : io_bus.addr_write;
            r_busWdata <= io_bus.wdata[7:0];
            r_busRead  <= io_bus.req_read;
            r_busWrite <= ~io_bus.req_read;
            r_wait     <= 8'h00;
          end
        end
        LO: begin
          if (io_bus.bus_ready) begin
            if (r_isRead) begin
              if (r_wide) r_loByte <= io_bus.bus_rdata;
              else        r_memData <= {8'h00, io_bus.bus_rdata};
            end
            r_wait <= 8'h00;
            if (r_wide) begin
              r_state    <= HI;
              r_busAddr  <= r_addr + 16'd1;
              r_busWdata <= r_wdataHi;
            end else begin
              r_state    <= DONE;
              r_busRead  <= 1'b0;
              r_busWrite <= 1'b0;
              r_memAck   <= r_isRead;
              r_wrDone   <= ~r_isRead;
            end
          end else if (w_timeout) begin
            r_state    <= DONE;
            r_busRead  <= 1'b0;
            r_busWrite <= 1'b0;
            r_memAck   <= r_isRead;
            r_wrDone   <= ~r_isRead;
            r_err      <= 1'b1;
            r_wait     <= 8'h00;
            if (r_isRead) r_memData <= 16'h0000;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        HI: begin
          if (io_bus.bus_ready) begin
            if (r_isRead) r_memData <= {io_bus.bus_rdata, r_loByte};
            r_state    <= DONE;
            r_busRead  <= 1'b0;
            r_busWrite <= 1'b0;
            r_memAck   <= r_isRead;
            r_wrDone   <= ~r_isRead;
            r_wait     <= 8'h00;
          end else if (w_timeout) begin
            r_state    <= DONE;
            r_busRead  <= 1'b0;
            r_busWrite <= 1'b0;
            r_memAck   <= r_isRead;
            r_wrDone   <= ~r_isRead;
            r_err      <= 1'b1;
            r_wait     <= 8'h00;
            if (r_isRead) r_memData <= 16'h0000;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        DONE: begin
          // Requests seen here are ignored; a held request is taken next cycle in IDLE.
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.busy      = r_busy;
  assign io_bus.mem_ack   = r_memAck;
  assign io_bus.wr_done   = r_wrDone;
  assign io_bus.err       = r_err;
  assign io_bus.mem_data  = r_memData;
  assign io_bus.bus_addr  = r_busAddr;
  assign io_bus.bus_wdata = r_busWdata;
  assign io_bus.bus_read  = r_busRead;
  assign io_bus.bus_write = r_busWrite;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: a cycle-level bus responder per transaction
// plus a scoreboard of expected completions popped when mem_ack/wr_done appears.
module tb_memory_access_unit;

  localparam logic [7:0] TMO = 8'd6;
  localparam int PH_LO   = 0;
  localparam int PH_HI   = 1;
  localparam int PH_DONE = 2;
  localparam int PH_IDLE = 3;

  logic clk = 1'b0;
  logic rst;

  memory_access_unit_if busIf ();

  memory_access_unit #(.BUS_TIMEOUT(TMO)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (busIf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          isRead;
    logic [15:0] data;
    bit          err;
    int          lat;
  } sbEntry_t;

  sbEntry_t    sbQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] lastRead = 16'h0000;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput(tag, {busIf.busy, busIf.mem_ack, busIf.wr_done, busIf.err,
                      busIf.bus_read, busIf.bus_write, busIf.bus_wdata},
                     {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    checkOutput({tag, "_addr_data"}, {busIf.bus_addr, busIf.mem_data}, 32'h0000_0000);
  endtask

  // One transaction from request to the idle cycle after DONE, with waits low-ready
  // cycles per phase (or ready stuck low), optional request hold and optional reset.
  task automatic applyStimulus(input string name, input bit rd, input bit wr, input bit wide,
                               input logic [15:0] aR, input logic [15:0] aW, input logic [15:0] wd,
                               input logic [7:0] loB, input logic [7:0] hiB,
                               input int waits, input bit stuck, input bit holdReq, input int rstAt);
    bit          isRead;
    logic [15:0] addr;
    logic [15:0] expAddr;
    logic [7:0]  expByte;
    int          per;
    int          nDone;
    int          k;
    int          idx;
    int          ph;
    sbEntry_t    e;
    sbEntry_t    got;

    isRead = rd;
    addr   = rd ? aR : aW;
    per    = waits + 1;
    nDone  = stuck ? int'(TMO) + 1 : (wide ? 2 : 1) * per + 1;
    e.isRead = isRead;
    e.err    = stuck;
    e.lat    = nDone;
    if (!isRead)    e.data = lastRead;
    else if (stuck) e.data = 16'h0000;
    else if (wide)  e.data = {hiB, loB};
    else            e.data = {8'h00, loB};
    if (rstAt == 0) sbQ.push_back(e);

    @(negedge clk);
    busIf.req_read   = rd;
    busIf.req_write  = wr;
    busIf.req_wide   = wide;
    busIf.addr_read  = aR;
    busIf.addr_write = aW;
    busIf.wdata      = wd;
    busIf.bus_ready  = 1'b0;
    busIf.bus_rdata  = 8'hA5;
    @(posedge clk);

    for (int n = 1; n <= nDone + 1; n++) begin
      @(negedge clk);
      k = n - 1;
      if (stuck)                   ph = (n <= int'(TMO)) ? PH_LO : (n == nDone) ? PH_DONE : PH_IDLE;
      else if (k < per)            ph = PH_LO;
      else if (wide && k < 2*per)  ph = PH_HI;
      else if (n == nDone)         ph = PH_DONE;
      else                         ph = PH_IDLE;
      idx = k % per;

      if (n == 1) begin
        busIf.addr_read  = ~aR;
        busIf.addr_write = ~aW;
        busIf.wdata      = ~wd;
        busIf.req_wide   = ~wide;
        if (!holdReq) begin
          busIf.req_read  = 1'b0;
          busIf.req_write = 1'b0;
        end
      end

      if (busIf.mem_ack || busIf.wr_done) begin
        checkOutput({name, "_sb_nonempty"}, 32'(sbQ.size() != 0), 32'd1);
        if (sbQ.size() != 0) begin
          got = sbQ.pop_front();
          checkOutput({name, "_sb"}, {busIf.mem_ack, busIf.wr_done, busIf.err, busIf.mem_data},
                                     {got.isRead, ~got.isRead, got.err, got.data});
          checkOutput({name, "_latency"}, n, got.lat);
        end
      end

      case (ph)
        PH_LO, PH_HI: begin
          expAddr = (ph == PH_HI) ? addr + 16'd1 : addr;
          expByte = (ph == PH_HI) ? wd[15:8] : wd[7:0];
          checkOutput({name, "_bus"},
                      {busIf.busy, busIf.bus_read, busIf.bus_write, busIf.mem_ack,
                       busIf.wr_done, busIf.err, busIf.bus_addr},
                      {1'b1, isRead, ~isRead, 1'b0, 1'b0, 1'b0, expAddr});
          if (!isRead) checkOutput({name, "_wdata"}, busIf.bus_wdata, expByte);
          busIf.bus_ready = !stuck && (idx == waits);
          busIf.bus_rdata = busIf.bus_ready ? ((ph == PH_HI) ? hiB : loB) : 8'hA5;
        end
        PH_DONE: begin
          checkOutput({name, "_done"},
                      {busIf.busy, busIf.bus_read, busIf.bus_write,
                       busIf.mem_ack, busIf.wr_done, busIf.err},
                      {1'b1, 1'b0, 1'b0, isRead, ~isRead, stuck});
          busIf.bus_ready = 1'b0;
          busIf.bus_rdata = 8'hA5;
        end
        default: begin
          checkOutput({name, "_idle"},
                      {busIf.busy, busIf.bus_read, busIf.bus_write,
                       busIf.mem_ack, busIf.wr_done, busIf.err},
                      32'd0);
          checkOutput({name, "_hold_data"}, busIf.mem_data, e.data);
          busIf.req_read  = 1'b0;
          busIf.req_write = 1'b0;
        end
      endcase

      if (rstAt != 0 && n == rstAt) begin
        rst = 1'b1;
        @(negedge clk);
        checkResetState({name, "_reset"});
        rst = 1'b0;
        busIf.req_read  = 1'b0;
        busIf.req_write = 1'b0;
        busIf.bus_ready = 1'b0;
        lastRead = 16'h0000;
        for (int q = 0; q < 3; q++) begin
          @(negedge clk);
          checkOutput({name, "_after_reset"},
                      {busIf.busy, busIf.mem_ack, busIf.wr_done, busIf.err,
                       busIf.bus_read, busIf.bus_write},
                      32'd0);
        end
        return;
      end
    end

    if (isRead) lastRead = e.data;
    checkOutput({name, "_sb_empty"}, sbQ.size(), 0);
  endtask

  initial begin
    rst              = 1'b1;
    busIf.req_read   = 1'b0;
    busIf.req_write  = 1'b0;
    busIf.req_wide   = 1'b0;
    busIf.addr_read  = 16'h0000;
    busIf.addr_write = 16'h0000;
    busIf.wdata      = 16'h0000;
    busIf.bus_rdata  = 8'h00;
    busIf.bus_ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetState("reset_state");
    rst = 1'b0;

    applyStimulus("narrow_read",   1, 0, 0, 16'hC000, 16'h0000, 16'h0000, 8'h5A, 8'h00, 0, 0, 0, 0);
    applyStimulus("wide_write_wrap", 0, 1, 1, 16'h0000, 16'hFFFF, 16'hBEEF, 8'h00, 8'h00, 0, 0, 0, 0);
    applyStimulus("wide_read_wait", 1, 0, 1, 16'h1000, 16'h0000, 16'h0000, 8'h34, 8'h12, 2, 0, 0, 0);
    applyStimulus("both_req",      1, 1, 0, 16'h2000, 16'h3000, 16'h5566, 8'h77, 8'h00, 1, 0, 0, 0);
    applyStimulus("narrow_write",  0, 1, 0, 16'h0000, 16'h4000, 16'h1199, 8'h00, 8'h00, 1, 0, 0, 0);
    applyStimulus("max_wait_ok",   1, 0, 0, 16'h4321, 16'h0000, 16'h0000, 8'h3C, 8'h00, int'(TMO) - 1, 0, 0, 0);
    applyStimulus("timeout_read",  1, 0, 1, 16'h8000, 16'h0000, 16'h0000, 8'h99, 8'h88, 0, 1, 0, 0);
    applyStimulus("timeout_write", 0, 1, 1, 16'h0000, 16'h9000, 16'hCAFE, 8'h00, 8'h00, 0, 1, 0, 0);
    applyStimulus("held_req",      1, 0, 0, 16'h5555, 16'h0000, 16'h0000, 8'hC3, 8'h00, 0, 0, 1, 0);
    applyStimulus("reset_in_hi",   1, 0, 1, 16'h6000, 16'h0000, 16'h0000, 8'hAB, 8'hCD, 0, 0, 0, 2);
    applyStimulus("post_reset",    1, 0, 1, 16'h7FFF, 16'h0000, 16'h0000, 8'h11, 8'h22, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 Parameter: BUS_TIMEOUT, default 8'd255; maximum bus_ready wait, in cycles, per byte phase before abort.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 req_read  input  1  read request from the control unit.
REQ-005 req_write  input  1  write request from the control unit.
REQ-006 req_wide  input  1  1 = 16-bit access; 0 = 8-bit access.
REQ-007 addr_read  input  16  read address (register-file reg_mem_addr_read).
REQ-008 addr_write  input  16  write address (register-file reg_mem_addr_write).
REQ-009 wdata  input  16  write data; [7:0] is the low byte.
REQ-010 busy  output  1  1 whenever state is not IDLE.
REQ-011 mem_ack  output  1  one-cycle pulse on read completion; feeds register-file mem_ack.
REQ-012 mem_data  output  16  assembled read data; feeds register-file mem_data.
REQ-013 wr_done  output  1  one-cycle pulse on write completion.
REQ-014 err  output  1  one-cycle pulse, coincident with mem_ack/wr_done, on timeout abort.
REQ-015 bus_addr  output  16  byte address on the 8-bit memory bus.
REQ-016 bus_rdata  input  8  bus read byte.
REQ-017 bus_wdata  output  8  bus write byte.
REQ-018 bus_read, bus_write  output  1 each  bus strobes; mutually exclusive.
REQ-019 bus_ready  input  1  bus completes the current byte when sampled high.

Function
REQ-020 FSM states: IDLE, LO, HI, DONE; all outputs are driven from registered state only.
REQ-021 Acceptance occurs only in IDLE when req_read or req_write is high; both high = read accepted, write ignored.
REQ-022 On acceptance, latch direction, req_wide, address (addr_read or addr_write) and wdata; go to LO.
REQ-023 Later input changes have no effect until the next return to IDLE.
REQ-024 LO: bus_addr = latched addr; bus_read or bus_write = 1; bus_wdata = wdata[7:0].
REQ-025 LO, on bus_ready = 1: capture bus_rdata into the low byte; go to HI if wide, else DONE.
REQ-026 HI: bus_addr = addr+1, mod 2^16 (16'hFFFF wraps to 16'h0000); bus_wdata = wdata[15:8].
REQ-027 HI, on bus_ready = 1: capture bus_rdata into the high byte; go to DONE.
REQ-028 Strobes and bus_addr stay stable throughout LO/HI until bus_ready is sampled; strobes are 0 in IDLE and DONE.
REQ-029 DONE lasts exactly one cycle, then IDLE.
REQ-030 DONE, read: mem_ack = 1. DONE, write: wr_done = 1. Never both.
REQ-031 Narrow read: mem_data = {8'h00, byte}. Wide read: mem_data = {high, low}.
REQ-032 mem_data updates only on capture; holds between reads; unaffected by writes.
REQ-033 Latency with bus_ready held high, accept at edge T: narrow completes in 3 cycles (LO T+1, DONE T+2, IDLE T+3); wide completes in 4.
REQ-034 Each wait cycle with bus_ready low adds one cycle.
REQ-035 Per-phase wait counter clears on entry to LO and to HI.
REQ-036 If the counter reaches BUS_TIMEOUT with bus_ready low: abort to DONE, pulse err, set mem_data = 16'h0000 for reads, skip remaining phase.
REQ-037 A request asserted during DONE is not accepted; it is accepted in IDLE if still held.

Reset
REQ-038 rst high at a clock edge forces IDLE from any state, including mid-transfer; aborted transfer produces no mem_ack/wr_done/err.
REQ-039 Reset values: busy 0, mem_ack 0, wr_done 0, err 0, mem_data 16'h0000, bus_addr 16'h0000, bus_wdata 8'h00, bus_read 0, bus_write 0; wait counter 0.

Verification
REQ-040 Narrow read: addr_read=16'hC000, bus_rdata=8'h5A, bus_ready=1 -> bus_read cycle T+1 at C000, mem_ack at T+2, mem_data=16'h005A.
REQ-041 Wide write: addr_write=16'hFFFF, wdata=16'hBEEF -> bytes EF@FFFF then BE@0000, wr_done at T+3, mem_ack stays 0.
REQ-042 Wide read with 2 wait cycles per phase: bytes 34@1000 then 12@1001 -> mem_data=16'h1234, mem_ack at T+7.
REQ-043 req_read and req_write both high -> read performed; bus_write never asserted.
REQ-044 bus_ready stuck low -> err and mem_ack together after BUS_TIMEOUT wait cycles, mem_data=16'h0000, then IDLE.
REQ-045 rst asserted during HI of a wide read -> next cycle IDLE, strobes 0, no mem_ack; next request proceeds normally.
